// File: rtl/display_pkg.sv
// Shared 7-segment constants (active-low form) and reader FSM states.
// The board segment encoder builds its table from the same SEG_* values.
package display_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_NEG   = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] CODE_NEG   = 4'd10;
  localparam logic [3:0] CODE_BLANK = 4'd15;

  typedef enum logic [1:0] {WAIT, SETTLE, LOCKED} state_t;

endpackage

// File: rtl/display_reader_seg_decode.sv
// Combinational inverse of the segment encoder: normalised active-low
// pattern to 4-bit code, with o_ok low for undecodable patterns.
module seg_decode
  import display_pkg::*;
(
  input  logic [6:0] i_seg,
  output logic [3:0] o_code,
  output logic       o_ok
);

  always_comb begin
    o_code = '0;
    o_ok   = 1'b1;
    case (i_seg)
      SEG_0:     o_code = 4'd0;
      SEG_1:     o_code = 4'd1;
      SEG_2:     o_code = 4'd2;
      SEG_3:     o_code = 4'd3;
      SEG_4:     o_code = 4'd4;
      SEG_5:     o_code = 4'd5;
      SEG_6:     o_code = 4'd6;
      SEG_7:     o_code = 4'd7;
      SEG_8:     o_code = 4'd8;
      SEG_9:     o_code = 4'd9;
      SEG_NEG:   o_code = CODE_NEG;
      SEG_BLANK: o_code = CODE_BLANK;
      default:   o_ok   = 1'b0;
    endcase
  end

endmodule

// File: rtl/display_reader.sv
// Reads back a multiplexed 7-segment bus: each strobe window is captured
// once it has shown STABLE_CYCLES identical samples.
module display_reader
  import display_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int TYPE          = 0,
  parameter int AN_ACTIVE_LOW = 1,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [6:0]            seg,
  input  logic [DIGITS-1:0]     an,
  output logic [4*DIGITS-1:0]   digits,
  output logic [DIGITS-1:0]     valid,
  output logic [DIGITS-1:0]     error,
  output logic                  update,
  output logic                  frame_done
);

  localparam int CNT_W = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 2);

  logic [6:0]          w_s;
  logic [DIGITS-1:0]   w_sel;
  logic                w_legal;
  logic                w_same;
  logic [3:0]          w_code;
  logic                w_ok;
  logic [DIGITS-1:0]   w_valid_nxt;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [DIGITS+6:0]   r_sample;
  logic [4*DIGITS-1:0] r_digits;
  logic [DIGITS-1:0]   r_valid;
  logic [DIGITS-1:0]   r_error;
  logic                r_update;
  logic                r_frame_done;

  assign w_s     = (TYPE != 0) ? ~seg : seg;
  assign w_sel   = (AN_ACTIVE_LOW != 0) ? ~an : an;
  assign w_legal = (w_sel != '0) && ((w_sel & (w_sel - DIGITS'(1))) == '0);
  assign w_same  = ({w_sel, w_s} == r_sample);

  seg_decode u_dec (
    .i_seg  (w_s),
    .o_code (w_code),
    .o_ok   (w_ok)
  );

  // Valid vector as it will stand after a capture; frame_done needs the
  // freshly written bit, not the registered one.
  always_comb begin
    w_valid_nxt = r_valid;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (w_sel[i]) w_valid_nxt[i] = w_ok;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= WAIT;
      r_cnt        <= '0;
      r_sample     <= '0;
      r_digits     <= '0;
      r_valid      <= '0;
      r_error      <= '0;
      r_update     <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_sample     <= {w_sel, w_s};
      r_update     <= 1'b0;
      r_frame_done <= 1'b0;
      case (r_state)
        WAIT: begin
          r_cnt <= '0;
          if (w_legal) r_state <= SETTLE;
        end
        SETTLE: begin
          if (!w_legal) begin
            r_state <= WAIT;
            r_cnt   <= '0;
          end else if (!w_same) begin
            r_cnt <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_state      <= LOCKED;
            r_update     <= 1'b1;
            r_valid      <= w_valid_nxt;
            r_frame_done <= w_sel[DIGITS-1] && (&w_valid_nxt);
            for (int unsigned i = 0; i < DIGITS; i++) begin
              if (w_sel[i]) begin
                r_error[i] <= !w_ok;
                if (w_ok) r_digits[4*i +: 4] <= w_code;
              end
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        LOCKED: begin
          if (!w_same) begin
            r_cnt   <= '0;
            r_state <= w_legal ? SETTLE : WAIT;
          end
        end
        default: begin
          r_state <= WAIT;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign digits     = r_digits;
  assign valid      = r_valid;
  assign error      = r_error;
  assign update     = r_update;
  assign frame_done = r_frame_done;

endmodule

// File: doc/display_reader.md
Name: display_reader

Overview:
- Decodes a time-multiplexed 7-segment display bus back into per-digit 4-bit codes. This is the inverse of the segment encoder used on the board displays.
- Samples the segment lines and the anode strobes, then waits for each strobe window to settle before capturing it.
- Outputs the digit codes with valid and error flags.
- Sits on the debug/self-check path. It lets the CPU test harness read back what the display drivers are actually showing.

Parameters:
- DIGITS, 4: number of multiplexed digits (anode lines). Must be 1..8.
- TYPE, 0: segment polarity. 0 = active-low segments (pattern for 0 is 7'b1000000). 1 = active-high (all seg bits inverted before decode).
- AN_ACTIVE_LOW, 1: 1 = an[i]==0 selects digit i; 0 = an[i]==1 selects digit i.
- STABLE_CYCLES, 4: number of consecutive identical samples required for a capture. Must be >=2.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- seg  in  7  segment lines {g,f,e,d,c,b,a}, bit0 = a. Synchronous to clk.
- an  in  DIGITS  anode strobes. Synchronous to clk.
- digits  out  4*DIGITS  decoded codes; digit i occupies bits [4i+3:4i].
- valid  out  DIGITS  digit i field holds a successfully decoded capture.
- error  out  DIGITS  last capture of digit i was an undecodable pattern.
- update  out  1  one-cycle pulse on every capture.
- frame_done  out  1  one-cycle pulse when digit DIGITS-1 is captured and all valid bits are 1 after that capture.

Behaviour:
- Reset: digits=0, valid=0, error=0, update=0, frame_done=0, state=WAIT, cnt=0, sample register=0. Reset has priority over any same-edge capture.
- Normalisation:
  - s = TYPE ? ~seg : seg.
  - sel = AN_ACTIVE_LOW ? ~an : an.
  - Strobe is legal only if sel is one-hot. Zero or multiple active lines is illegal.
- Decode of s (active-low form):
  - 1000000→0, 1111001→1, 0100100→2, 0110000→3, 0011001→4, 0010010→5, 0000010→6, 1111000→7, 0000000→8, 0010000→9.
  - 0111111→10 (negative sign). 1111111→15 (blank).
  - Any other pattern is undecodable.
- Sample register r <= {sel,s} every cycle. "same" = ({sel,s}==r).
- FSM:
  - WAIT: strobe illegal. cnt=0. Go to SETTLE when strobe is legal.
  - SETTLE:
    - If strobe is illegal, go to WAIT and set cnt=0.
    - Else if !same, stay in SETTLE and set cnt=0 (restart on the new value).
    - Else if cnt==STABLE_CYCLES-2, capture and go to LOCKED.
    - Else cnt<=cnt+1.
  - LOCKED: no further capture.
    - On !same, set cnt=0 and go to SETTLE if the strobe is legal, else go to WAIT.
    - Re-presenting an identical value after a change is a new capture.
- Latency: a value applied before edge k and held is captured at edge k+STABLE_CYCLES-1 (STABLE_CYCLES identical samples). The outputs and update are visible after that edge.
- Capture of digit i (i = index of the set bit in sel):
  - Decodable pattern: digits[i] = code, valid[i]=1, error[i]=0.
  - Undecodable pattern: digits[i] unchanged, valid[i]=0, error[i]=1.
  - update=1 for exactly one cycle.
  - frame_done=1 the same cycle if i==DIGITS-1 and all valid bits (including the new one) are 1.
  - Other digits' fields and flags are untouched.
- update and frame_done are 0 in every non-capture cycle. Back-to-back captures are impossible, because each needs at least STABLE_CYCLES cycles.
- cnt width = $clog2(STABLE_CYCLES). It never exceeds STABLE_CYCLES-2.

Decomposition:
- Shared package display_pkg:
  - Segment pattern constants SEG_0..SEG_9, SEG_NEG, SEG_BLANK (active-low).
  - Code constants CODE_NEG=10, CODE_BLANK=15.
  - FSM state enum {WAIT, SETTLE, LOCKED}.
  - The existing encoder should take its table from the same constants.
- One combinational sub-module, seg_decode: 7-bit normalised pattern in → 4-bit code plus ok flag.
- One-hot check and index encoding stay inline.

Test Plan:
- Capture: TYPE=0, AN_ACTIVE_LOW=1, STABLE_CYCLES=4. After reset, hold an=4'b1110, seg=7'b0100100 for 6 cycles → digits[3:0]=2 and valid=4'b0001 after the 4th edge. update high exactly 1 cycle. No second pulse while the inputs are held.
- Glitch: seg=7'b0110000 for 2 cycles, then 7'b0011001 held → no capture of 3. Digit0=4 after 4 cycles of the new value.
- Bad strobe and bad pattern:
  - an=4'b1100 or 4'b1111 with a legal seg held 10 cycles → no update, state stays WAIT.
  - an=4'b1101 with seg=7'b1010101 held 4 cycles → error[1]=1, valid[1]=0, digits[7:4] unchanged.
- Full scan: digits 0..3 show 1, 2, 3, negative in order, each held 5 cycles → digits=16'hA321, valid=4'hF. frame_done pulses once, on the digit-3 capture.
- TYPE=1 / AN_ACTIVE_LOW=0: seg=7'b1111111 (active-high 8), an=4'b0100 held 4 cycles → digits[11:8]=8. Then seg=0 → digits[11:8]=15 (blank), valid[2]=1.
- Reset precedence: assert reset on the edge where the 4th identical sample arrives → all outputs 0, no update. Capture resumes only after 4 fresh stable cycles following reset release.
